// File: rtl/median_axi_master_if.sv
// AXI4-Lite bundle between the median initiator and the sorter slave; master drives
// requests, slave drives responses.
interface median_axi_master_if #(
    parameter int ADDR_WIDTH = 40,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
    logic [2:0]              M_AXI_AWPROT;
    logic                    M_AXI_AWVALID;
    logic                    M_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
    logic                    M_AXI_WVALID;
    logic                    M_AXI_WREADY;
    logic [1:0]              M_AXI_BRESP;
    logic                    M_AXI_BVALID;
    logic                    M_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR;
    logic [2:0]              M_AXI_ARPROT;
    logic                    M_AXI_ARVALID;
    logic                    M_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_RDATA;
    logic [1:0]              M_AXI_RRESP;
    logic                    M_AXI_RVALID;
    logic                    M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/median_axi_master.sv
// AXI4-Lite initiator for the 3x3 sorter: 3 writes, settle, 1 read; min 9+SETTLE_CYCLES+3 cycles.
// in_ready only in IDLE, result held until out_ready; MEDIAN_TIMEOUT_EN adds a per-wait watchdog.
module median_axi_master #(
    parameter int                            C_M_AXI_ADDR_WIDTH = 40,
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = 40'h00_A000_0000,
    parameter int                            SETTLE_CYCLES      = 2,
    parameter int                            TIMEOUT_CYCLES     = 1023
) (
    input  logic                M_AXI_ACLK,
    input  logic                M_AXI_ARESETN,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [71:0]         in_pix,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_max,
    output logic [7:0]          out_med,
    output logic [7:0]          out_min,
    output logic                out_err,
    output logic                busy,
    median_axi_master_if.master m_axi
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_RESP, SETTLE, RD_REQ, RD_RESP, DONE
    } state_t;

    state_t        state, state_d;
    logic [71:0]   pix_q;
    logic [1:0]    k;
    logic          aw_done, w_done;
    logic [SW-1:0] scnt;
    logic          err_q;
    logic [7:0]    max_q, med_q, min_q;
    logic [23:0]   win;
    logic          aw_vld, w_vld, b_rdy, ar_vld, r_rdy, rdy_in, vld_out;
    logic          unused_rdata;

`ifdef MEDIAN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    logic          tmo_fire;

    // Counts cycles spent in the current state; any state change restarts it.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN)        tcnt <= '0;
        else if (state_d != state) tcnt <= '0;
        else                       tcnt <= tcnt + 1'b1;
    end
`endif

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) state <= IDLE;
        else                state <= state_d;
    end

    always_comb begin
        state_d = state;
        aw_vld  = 1'b0;
        w_vld   = 1'b0;
        b_rdy   = 1'b0;
        ar_vld  = 1'b0;
        r_rdy   = 1'b0;
        rdy_in  = 1'b0;
        vld_out = 1'b0;
`ifdef MEDIAN_TIMEOUT_EN
        tmo_fire = 1'b0;
`endif
        case (state)
            IDLE: begin
                rdy_in = 1'b1;
                if (in_valid) state_d = WR_REQ;
            end
            WR_REQ: begin
                aw_vld = !aw_done;
                w_vld  = !w_done;
                if ((aw_done || m_axi.M_AXI_AWREADY) && (w_done || m_axi.M_AXI_WREADY))
                    state_d = WR_RESP;
            end
            WR_RESP: begin
                b_rdy = 1'b1;
                if (m_axi.M_AXI_BVALID) state_d = (k == 2'd2) ? SETTLE : WR_REQ;
            end
            SETTLE: begin
                if (scnt == SW'(SETTLE_CYCLES - 1)) state_d = RD_REQ;
            end
            RD_REQ: begin
                ar_vld = 1'b1;
                if (m_axi.M_AXI_ARREADY) state_d = RD_RESP;
            end
            RD_RESP: begin
                r_rdy = 1'b1;
                if (m_axi.M_AXI_RVALID) state_d = DONE;
            end
            DONE: begin
                vld_out = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef MEDIAN_TIMEOUT_EN
        // A handshake landing on the last allowed cycle still wins over the watchdog.
        if ((state == WR_REQ || state == WR_RESP || state == RD_REQ || state == RD_RESP) &&
            tcnt == TW'(TIMEOUT_CYCLES - 1) && state_d == state) begin
            tmo_fire = 1'b1;
            state_d  = DONE;
        end
`endif
    end

    always_comb begin
        case (k)
            2'd0:    win = pix_q[71:48];
            2'd1:    win = pix_q[47:24];
            default: win = pix_q[23:0];
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            pix_q   <= '0;
            k       <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            scnt    <= '0;
            err_q   <= 1'b0;
            max_q   <= '0;
            med_q   <= '0;
            min_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        pix_q <= in_pix;
                        err_q <= 1'b0;
                        k     <= '0;
                    end
                end
                WR_REQ: begin
                    if (aw_vld && m_axi.M_AXI_AWREADY) aw_done <= 1'b1;
                    if (w_vld && m_axi.M_AXI_WREADY)   w_done  <= 1'b1;
                end
                WR_RESP: begin
                    if (m_axi.M_AXI_BVALID) begin
                        err_q <= err_q | (m_axi.M_AXI_BRESP != 2'b00);
                        if (k != 2'd2) k <= k + 2'd1;
                    end
                end
                RD_RESP: begin
                    if (m_axi.M_AXI_RVALID) begin
                        max_q <= m_axi.M_AXI_RDATA[23:16];
                        med_q <= m_axi.M_AXI_RDATA[15:8];
                        min_q <= m_axi.M_AXI_RDATA[7:0];
                        err_q <= err_q | (m_axi.M_AXI_RRESP != 2'b00);
                    end
                end
                default: ;
            endcase
            // Per-channel done flags only live for one write beat.
            if (state_d != WR_REQ) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            scnt <= (state == SETTLE) ? scnt + 1'b1 : '0;
`ifdef MEDIAN_TIMEOUT_EN
            if (tmo_fire) begin
                max_q <= '0;
                med_q <= '0;
                min_q <= '0;
                err_q <= 1'b1;
            end
`endif
        end
    end

    assign unused_rdata = ^m_axi.M_AXI_RDATA[31:24];

    assign m_axi.M_AXI_AWVALID = aw_vld;
    assign m_axi.M_AXI_AWADDR  = (state == WR_REQ) ? BASE_ADDR + AW'({k, 2'b00}) : '0;
    assign m_axi.M_AXI_AWPROT  = 3'b000;
    assign m_axi.M_AXI_WVALID  = w_vld;
    assign m_axi.M_AXI_WDATA   = (state == WR_REQ) ? C_M_AXI_DATA_WIDTH'({8'h00, win}) : '0;
    assign m_axi.M_AXI_WSTRB   = (state == WR_REQ) ? 4'hF : 4'h0;
    assign m_axi.M_AXI_BREADY  = b_rdy;
    assign m_axi.M_AXI_ARVALID = ar_vld;
    assign m_axi.M_AXI_ARADDR  = (state == RD_REQ) ? BASE_ADDR + AW'(12) : '0;
    assign m_axi.M_AXI_ARPROT  = 3'b000;
    assign m_axi.M_AXI_RREADY  = r_rdy;

    assign in_ready  = rdy_in;
    assign out_valid = vld_out;
    assign out_max   = max_q;
    assign out_med   = med_q;
    assign out_min   = min_q;
    assign out_err   = err_q;
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_median_axi_master.sv
// Directed bench for median_axi_master with a small reactive AXI4-Lite slave model.
module tb_median_axi_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [71:0] in_pix = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_max, out_med, out_min;
    logic        out_err, busy;

    int total = 0;
    int bad = 0;

    median_axi_master_if #(.ADDR_WIDTH(40), .DATA_WIDTH(32)) axi ();

    median_axi_master #(
        .C_M_AXI_ADDR_WIDTH(40), .C_M_AXI_DATA_WIDTH(32), .BASE_ADDR(40'h00_A000_0000),
        .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_max(out_max), .out_med(out_med), .out_min(out_min),
        .out_err(out_err), .busy(busy), .m_axi(axi)
    );

    always #5 clk = ~clk;

    // Slave model configuration and transaction logs.
    int          aw_delay = 0;
    int          bad_b_idx = -1;
    logic        ar_ok = 1'b1;
    logic [31:0] rdata_cfg = '0;
    logic [39:0] aw_log [0:63];
    logic [31:0] w_log  [0:63];
    logic [39:0] ar_log [0:63];
    int          aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, arv_cyc = 0, aw_cnt = 0;
    logic        aw_got = 1'b0, w_got = 1'b0;

    assign axi.M_AXI_WREADY = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            axi.M_AXI_AWREADY <= (aw_delay == 0);
            axi.M_AXI_BVALID  <= 1'b0;
            axi.M_AXI_BRESP   <= 2'b00;
            axi.M_AXI_ARREADY <= 1'b0;
            axi.M_AXI_RVALID  <= 1'b0;
            axi.M_AXI_RDATA   <= '0;
            axi.M_AXI_RRESP   <= 2'b00;
            aw_cnt <= 0;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
        end else begin
            if (axi.M_AXI_AWVALID && axi.M_AXI_AWREADY) begin
                aw_log[aw_n[5:0]] <= axi.M_AXI_AWADDR;
                aw_n   <= aw_n + 1;
                aw_got <= 1'b1;
                aw_cnt <= 0;
                axi.M_AXI_AWREADY <= (aw_delay == 0);
            end else if (!axi.M_AXI_AWVALID) begin
                aw_cnt <= 0;
                axi.M_AXI_AWREADY <= (aw_delay == 0);
            end else begin
                aw_cnt <= aw_cnt + 1;
                if (aw_cnt + 1 >= aw_delay) axi.M_AXI_AWREADY <= 1'b1;
            end
            if (axi.M_AXI_WVALID && axi.M_AXI_WREADY) begin
                w_log[w_n[5:0]] <= axi.M_AXI_WDATA;
                w_n   <= w_n + 1;
                w_got <= 1'b1;
            end
            if (axi.M_AXI_BVALID && axi.M_AXI_BREADY) begin
                axi.M_AXI_BVALID <= 1'b0;
                b_n <= b_n + 1;
            end else if (aw_got && w_got && !axi.M_AXI_BVALID) begin
                axi.M_AXI_BVALID <= 1'b1;
                axi.M_AXI_BRESP  <= (b_n == bad_b_idx) ? 2'b10 : 2'b00;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            axi.M_AXI_ARREADY <= ar_ok;
            if (axi.M_AXI_ARVALID && axi.M_AXI_ARREADY) begin
                ar_log[ar_n[5:0]] <= axi.M_AXI_ARADDR;
                ar_n <= ar_n + 1;
                axi.M_AXI_RVALID <= 1'b1;
                axi.M_AXI_RDATA  <= rdata_cfg;
                axi.M_AXI_RRESP  <= 2'b00;
            end else if (axi.M_AXI_RVALID && axi.M_AXI_RREADY) begin
                axi.M_AXI_RVALID <= 1'b0;
            end
            if (axi.M_AXI_ARVALID) arv_cyc <= arv_cyc + 1;
        end
    end

    task automatic start_win(input logic [71:0] pix);
        @(negedge clk);
        in_pix   = pix;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name, output int lat);
        bit ok;
        ok  = 1'b0;
        lat = 1;
        for (int i = 0; i < 300; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_wait: out_valid=%0b after %0d cycles, want 1", name, out_valid, lat);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY, axi.M_AXI_ARVALID,
             axi.M_AXI_RREADY, out_valid, out_err, busy, in_ready} !== 9'b000000001) begin
            bad++;
            $display("FAIL reset_ctrl: got=%b want=000000001", {axi.M_AXI_AWVALID,
                axi.M_AXI_WVALID, axi.M_AXI_BREADY, axi.M_AXI_ARVALID, axi.M_AXI_RREADY,
                out_valid, out_err, busy, in_ready});
        end
        total++;
        if ({axi.M_AXI_AWADDR, axi.M_AXI_WDATA, axi.M_AXI_ARADDR, axi.M_AXI_WSTRB} !== '0) begin
            bad++;
            $display("FAIL reset_data: awaddr=%h wdata=%h araddr=%h strb=%h want 0",
                axi.M_AXI_AWADDR, axi.M_AXI_WDATA, axi.M_AXI_ARADDR, axi.M_AXI_WSTRB);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, baw, bw, bar;
        logic [39:0] exp_aw [3];
        logic [31:0] exp_w  [3];
        exp_aw = '{40'h00_A000_0000, 40'h00_A000_0004, 40'h00_A000_0008};
        exp_w  = '{32'h0001_0203, 32'h0004_0506, 32'h0007_0809};
        baw = aw_n; bw = w_n; bar = ar_n;
        rdata_cfg = 32'h0009_0501;
        start_win(72'h01_02_03_04_05_06_07_08_09);
        wait_out("basic", lat);
        total++;
        if (lat !== 14) begin
            bad++;
            $display("FAIL basic_latency: got=%0d want=14", lat);
        end
        total++;
        if ({out_max, out_med, out_min, out_err} !== {8'd9, 8'd5, 8'd1, 1'b0}) begin
            bad++;
            $display("FAIL basic_result: got=%0d/%0d/%0d err=%0b want=9/5/1 err=0",
                out_max, out_med, out_min, out_err);
        end
        total++;
        if ((aw_n - baw) !== 3 || (w_n - bw) !== 3 || (ar_n - bar) !== 1) begin
            bad++;
            $display("FAIL basic_counts: aw=%0d w=%0d ar=%0d want 3/3/1",
                aw_n - baw, w_n - bw, ar_n - bar);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (aw_log[6'(baw + i)] !== exp_aw[i] || w_log[6'(bw + i)] !== exp_w[i]) begin
                bad++;
                $display("FAIL basic_write%0d: addr=%h data=%h want %h/%h", i,
                    aw_log[6'(baw + i)], w_log[6'(bw + i)], exp_aw[i], exp_w[i]);
            end
        end
        total++;
        if (ar_log[6'(bar)] !== 40'h00_A000_000C) begin
            bad++;
            $display("FAIL basic_araddr: got=%h want=00a000000c", ar_log[6'(bar)]);
        end
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_busy: busy=%0b in_ready=%0b want 1/0", busy, in_ready);
        end
        consume();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_idle: in_ready=%0b out_valid=%0b busy=%0b want 1/0/0",
                in_ready, out_valid, busy);
        end
    endtask

    task automatic test_aw_delay();
        int lat;
        aw_delay = 3;
        rdata_cfg = 32'h0009_0501;
        @(negedge clk);
        start_win(72'h01_02_03_04_05_06_07_08_09);
        total++;
        if ({axi.M_AXI_AWVALID, axi.M_AXI_WVALID} !== 2'b11 ||
            axi.M_AXI_AWADDR !== 40'h00_A000_0000) begin
            bad++;
            $display("FAIL awdly_first: aw/w=%b addr=%h want 11/00a0000000",
                {axi.M_AXI_AWVALID, axi.M_AXI_WVALID}, axi.M_AXI_AWADDR);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({axi.M_AXI_AWVALID, axi.M_AXI_WVALID} !== 2'b10 ||
                axi.M_AXI_AWADDR !== 40'h00_A000_0000) begin
                bad++;
                $display("FAIL awdly_hold%0d: aw/w=%b addr=%h want 10/00a0000000", i,
                    {axi.M_AXI_AWVALID, axi.M_AXI_WVALID}, axi.M_AXI_AWADDR);
            end
        end
        wait_out("awdly", lat);
        total++;
        if ({out_max, out_med, out_min, out_err} !== {8'd9, 8'd5, 8'd1, 1'b0}) begin
            bad++;
            $display("FAIL awdly_result: got=%0d/%0d/%0d err=%0b want=9/5/1 err=0",
                out_max, out_med, out_min, out_err);
        end
        consume();
        aw_delay = 0;
        @(negedge clk);
    endtask

    task automatic test_bresp_err();
        int lat, baw, bar;
        baw = aw_n; bar = ar_n;
        bad_b_idx = b_n + 1;
        rdata_cfg = 32'h0007_0402;
        start_win(72'h02_03_04_05_06_07_08_09_01);
        wait_out("bresp", lat);
        total++;
        if ((aw_n - baw) !== 3 || (ar_n - bar) !== 1) begin
            bad++;
            $display("FAIL bresp_counts: aw=%0d ar=%0d want 3/1", aw_n - baw, ar_n - bar);
        end
        total++;
        if ({out_max, out_med, out_min, out_err} !== {8'd7, 8'd4, 8'd2, 1'b1}) begin
            bad++;
            $display("FAIL bresp_result: got=%0d/%0d/%0d err=%0b want=7/4/2 err=1",
                out_max, out_med, out_min, out_err);
        end
        consume();
        bad_b_idx = -1;
    endtask

    task automatic test_backpressure();
        int lat;
        rdata_cfg = 32'h00C8_640A;
        start_win(72'h0A_14_1E_28_32_3C_46_50_64);
        wait_out("bp", lat);
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({out_valid, in_ready, out_max, out_med, out_min, out_err} !==
                {1'b1, 1'b0, 8'd200, 8'd100, 8'd10, 1'b0}) begin
                bad++;
                $display("FAIL bp_hold%0d: v=%0b rdy=%0b res=%0d/%0d/%0d err=%0b want 1/0 200/100/10 0",
                    i, out_valid, in_ready, out_max, out_med, out_min, out_err);
            end
            @(negedge clk);
        end
        consume();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: in_ready=%0b want 1", in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bw;
        bw = w_n;
        rdata_cfg = 32'hAB09_0501;
        start_win(72'h09_08_07_06_05_04_03_02_01);
        wait_out("b2b_a", lat);
        total++;
        if ({out_max, out_med, out_min, out_err} !== {8'd9, 8'd5, 8'd1, 1'b0}) begin
            bad++;
            $display("FAIL b2b_a_result: got=%0d/%0d/%0d err=%0b want=9/5/1 err=0",
                out_max, out_med, out_min, out_err);
        end
        total++;
        if (w_log[6'(bw)] !== 32'h0009_0807 || w_log[6'(bw + 1)] !== 32'h0006_0504 ||
            w_log[6'(bw + 2)] !== 32'h0003_0201) begin
            bad++;
            $display("FAIL b2b_a_wdata: got=%h %h %h want 00090807 00060504 00030201",
                w_log[6'(bw)], w_log[6'(bw + 1)], w_log[6'(bw + 2)]);
        end
        consume();
        bw = w_n;
        rdata_cfg = 32'h0090_5010;
        start_win(72'h10_20_30_40_50_60_70_80_90);
        wait_out("b2b_b", lat);
        total++;
        if ({out_max, out_med, out_min, out_err} !== {8'h90, 8'h50, 8'h10, 1'b0}) begin
            bad++;
            $display("FAIL b2b_b_result: got=%h/%h/%h err=%0b want=90/50/10 err=0",
                out_max, out_med, out_min, out_err);
        end
        total++;
        if (w_log[6'(bw)] !== 32'h0010_2030 || w_log[6'(bw + 1)] !== 32'h0040_5060 ||
            w_log[6'(bw + 2)] !== 32'h0070_8090) begin
            bad++;
            $display("FAIL b2b_b_wdata: got=%h %h %h want 00102030 00405060 00708090",
                w_log[6'(bw)], w_log[6'(bw + 1)], w_log[6'(bw + 2)]);
        end
        consume();
    endtask

    task automatic test_mid_reset();
        int lat, baw;
        bit found;
        baw = aw_n;
        found = 1'b0;
        start_win(72'h01_02_03_04_05_06_07_08_09);
        for (int i = 0; i < 40; i++) begin
            if (axi.M_AXI_BREADY && (aw_n - baw) == 2) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL rst_find: WR_RESP of second write not seen, found=%0b want 1", found);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY, axi.M_AXI_ARVALID,
             axi.M_AXI_RREADY, out_valid, busy} !== 7'b0) begin
            bad++;
            $display("FAIL rst_async: ctrl=%b want 0000000", {axi.M_AXI_AWVALID,
                axi.M_AXI_WVALID, axi.M_AXI_BREADY, axi.M_AXI_ARVALID, axi.M_AXI_RREADY,
                out_valid, busy});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_release: in_ready=%0b busy=%0b want 1/0", in_ready, busy);
        end
        baw = aw_n;
        rdata_cfg = 32'h0009_0501;
        start_win(72'h01_02_03_04_05_06_07_08_09);
        wait_out("rst_recover", lat);
        total++;
        if (aw_log[6'(baw)] !== 40'h00_A000_0000 ||
            {out_max, out_med, out_min, out_err} !== {8'd9, 8'd5, 8'd1, 1'b0}) begin
            bad++;
            $display("FAIL rst_recover: addr=%h res=%0d/%0d/%0d err=%0b want 00a0000000 9/5/1 0",
                aw_log[6'(baw)], out_max, out_med, out_min, out_err);
        end
        consume();
    endtask

`ifdef MEDIAN_TIMEOUT_EN
    task automatic test_timeout();
        int lat, barv;
        barv = arv_cyc;
        ar_ok = 1'b0;
        start_win(72'h01_02_03_04_05_06_07_08_09);
        wait_out("tmo", lat);
        total++;
        if ({out_max, out_med, out_min, out_err, axi.M_AXI_ARVALID} !==
            {8'd0, 8'd0, 8'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL tmo_result: res=%0d/%0d/%0d err=%0b arvalid=%0b want 0/0/0 1 0",
                out_max, out_med, out_min, out_err, axi.M_AXI_ARVALID);
        end
        total++;
        if ((arv_cyc - barv) !== 16) begin
            bad++;
            $display("FAIL tmo_cycles: arvalid cycles=%0d want 16", arv_cyc - barv);
        end
        consume();
        ar_ok = 1'b1;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_aw_delay();
        test_bresp_err();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
`ifdef MEDIAN_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end
endmodule
